// File: rtl/pe_seq_ctrl_pkg.sv
// PE command codes and sequencer types shared by the row sequencer and the PE array top.
package pe_seq_ctrl_pkg;

    localparam int PE_CMD_RESET         = 0;
    localparam int PE_CMD_TRIGGER       = 1;
    localparam int PE_CMD_TRIGGER_LAST  = 2;
    localparam int PE_CMD_LOAD_DATA     = 5;
    localparam int PE_CMD_SET_CONV_MODE = 6;
    localparam int PE_CMD_FORWARD       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CFG,
        S_PRE,
        S_RUN,
        S_DRAIN,
        S_WAIT,
        S_DONE
    } pe_seq_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Operand stream in, broadcast PE command bus out; master is the sequencer side.
interface pe_seq_ctrl_if #(
    parameter int ACLEN      = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [DATA_WIDTH-1:0] s_weight;

    logic                  pe_cmd_valid;
    logic [ACLEN:0]        pe_cmd;
    logic [DATA_WIDTH-1:0] pe_param_1;
    logic [DATA_WIDTH-1:0] pe_param_2;
    logic [DATA_WIDTH-1:0] pe_preload;
    logic [DATA_WIDTH-1:0] pe_data;
    logic [DATA_WIDTH-1:0] pe_weight;

    modport master (
        input  s_valid, s_data, s_weight,
        output s_ready, pe_cmd_valid, pe_cmd, pe_param_1, pe_param_2,
               pe_preload, pe_data, pe_weight
    );

    modport slave (
        output s_valid, s_data, s_weight,
        input  s_ready, pe_cmd_valid, pe_cmd, pe_param_1, pe_param_2,
               pe_preload, pe_data, pe_weight
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Row sequencer: clears and configures the PE row, streams operand beats as
// TRIGGER commands, flushes the row skew, then waits for every PE to go idle.
module pe_seq_ctrl
    import pe_seq_ctrl_pkg::*;
#(
    parameter int ACLEN      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PE     = 8,
    parameter int MIN_WAIT   = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [15:0]           conv_len_i,
    input  logic                  preload_en_i,
    input  logic [DATA_WIDTH-1:0] preload_data_i,
    input  logic                  abort_i,
    input  logic [NUM_PE-1:0]     busy_i,
    pe_seq_ctrl_if.master         bus,
    output logic                  ctrl_busy_o,
    output logic                  done_o,
    output logic                  timeout_o
);
    localparam int CW      = ACLEN + 1;
    localparam int DRAIN_W = cnt_w(NUM_PE);
    localparam int WAIT_W  = cnt_w(TIMEOUT);

    pe_seq_state_e state_q, state_d;

    logic [15:0]           len_q, beat_q;
    logic                  pre_en_q;
    logic [DATA_WIDTH-1:0] pre_data_q;
    logic [DRAIN_W-1:0]    drain_q;
    logic [WAIT_W-1:0]     wait_q;
    logic                  timeout_q, set_timeout;
    logic                  accept, last_beat, drain_end, wait_ok, wait_to;

    logic                  cmd_vld_d, cmd_vld_q;
    logic [CW-1:0]         cmd_d, cmd_q;
    logic [DATA_WIDTH-1:0] p1_d, p1_q, pre_d, pre_q, data_d, data_q, wgt_d, wgt_q;

    assign bus.s_ready = (state_q == S_RUN) && !abort_i;
    assign accept      = bus.s_ready && bus.s_valid;
    assign last_beat   = (beat_q == len_q - 16'd1);
    assign drain_end   = (drain_q == DRAIN_W'(NUM_PE - 2));
    assign wait_ok     = (wait_q >= WAIT_W'(MIN_WAIT)) && (busy_i == '0);
    assign wait_to     = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus the command to present on the bus next cycle.
    always_comb begin
        state_d     = state_q;
        set_timeout = 1'b0;
        cmd_vld_d   = 1'b0;
        cmd_d       = '0;
        p1_d        = '0;
        pre_d       = '0;
        data_d      = '0;
        wgt_d       = '0;
        if (state_q != S_IDLE && abort_i) begin
            state_d   = S_IDLE;
            cmd_vld_d = 1'b1;
            cmd_d     = CW'(PE_CMD_RESET);
        end else begin
            case (state_q)
                S_IDLE: if (start_i) state_d = S_CLR;
                S_CLR: begin
                    cmd_vld_d = 1'b1;
                    cmd_d     = CW'(PE_CMD_RESET);
                    state_d   = S_CFG;
                end
                S_CFG: begin
                    cmd_vld_d = 1'b1;
                    cmd_d     = CW'(PE_CMD_SET_CONV_MODE);
                    p1_d      = DATA_WIDTH'(len_q);
                    if (len_q == 16'd0) state_d = S_DONE;
                    else if (pre_en_q)  state_d = S_PRE;
                    else                state_d = S_RUN;
                end
                S_PRE: begin
                    cmd_vld_d = 1'b1;
                    cmd_d     = CW'(PE_CMD_LOAD_DATA);
                    pre_d     = pre_data_q;
                    state_d   = S_RUN;
                end
                S_RUN: if (accept) begin
                    cmd_vld_d = 1'b1;
                    cmd_d     = last_beat ? CW'(PE_CMD_TRIGGER_LAST) : CW'(PE_CMD_TRIGGER);
                    data_d    = bus.s_data;
                    wgt_d     = bus.s_weight;
                    if (last_beat) state_d = (NUM_PE > 1) ? S_DRAIN : S_WAIT;
                end
                S_DRAIN: begin
                    cmd_vld_d = 1'b1;
                    cmd_d     = CW'(PE_CMD_FORWARD);
                    if (drain_end) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (wait_ok) begin
                        state_d = S_DONE;
                    end else if (wait_to) begin
                        state_d     = S_DONE;
                        set_timeout = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q      <= '0;
            pre_en_q   <= 1'b0;
            pre_data_q <= '0;
            beat_q     <= '0;
            drain_q    <= '0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            cmd_vld_q  <= 1'b0;
            cmd_q      <= '0;
            p1_q       <= '0;
            pre_q      <= '0;
            data_q     <= '0;
            wgt_q      <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                len_q      <= conv_len_i;
                pre_en_q   <= preload_en_i;
                pre_data_q <= preload_data_i;
            end
            // Counters run only inside their own state and restart from zero on entry.
            beat_q  <= (state_q == S_RUN)   ? beat_q + 16'(accept)       : '0;
            drain_q <= (state_q == S_DRAIN) ? drain_q + DRAIN_W'(1)      : '0;
            wait_q  <= (state_q == S_WAIT)  ? wait_q + WAIT_W'(1)        : '0;
            if (state_q == S_IDLE && start_i) timeout_q <= 1'b0;
            else if (set_timeout)             timeout_q <= 1'b1;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            p1_q      <= p1_d;
            pre_q     <= pre_d;
            data_q    <= data_d;
            wgt_q     <= wgt_d;
        end
    end

    assign bus.pe_cmd_valid = cmd_vld_q;
    assign bus.pe_cmd       = cmd_q;
    assign bus.pe_param_1   = p1_q;
    assign bus.pe_param_2   = '0;
    assign bus.pe_preload   = pre_q;
    assign bus.pe_data      = data_q;
    assign bus.pe_weight    = wgt_q;

    assign ctrl_busy_o = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE) && !abort_i;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: job-level reference model compared every cycle, directed scenarios, random traffic.
module tb_pe_seq_ctrl;

    localparam int NPE  = 8;
    localparam int MINW = 16;
    localparam int TMO  = 4096;
    localparam int C_RESET = 0, C_TRIG = 1, C_TLAST = 2, C_LOAD = 5, C_CONV = 6, C_FWD = 8;

    typedef struct packed {
        logic        vld;
        logic [8:0]  cmd;
        logic [31:0] p1, p2, pre, data, wgt;
    } cmd_t;

    logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, preload_en_i = 1'b0, abort_i = 1'b0;
    logic [15:0] conv_len_i = '0;
    logic [31:0] preload_data_i = '0;
    logic [7:0]  busy_i = '0;
    logic        ctrl_busy_o, done_o, timeout_o;

    pe_seq_ctrl_if #(.ACLEN(8), .DATA_WIDTH(32)) bus ();

    pe_seq_ctrl #(.ACLEN(8), .DATA_WIDTH(32), .NUM_PE(NPE), .MIN_WAIT(MINW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .conv_len_i(conv_len_i),
        .preload_en_i(preload_en_i), .preload_data_i(preload_data_i), .abort_i(abort_i),
        .busy_i(busy_i), .bus(bus), .ctrl_busy_o(ctrl_busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_pass = 0, cyc_n = 0;
    int n_done = 0, done_cyc = 0, fwd_cyc = 0, st_cyc = 0;
    cmd_t log_q[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    endtask

    function automatic cmd_t mk(input int code, input logic [31:0] p1, input logic [31:0] pre,
                                input logic [31:0] data, input logic [31:0] wgt);
        cmd_t r;
        r.vld = 1'b1; r.cmd = 9'(code); r.p1 = p1; r.p2 = '0;
        r.pre = pre; r.data = data; r.wgt = wgt;
        return r;
    endfunction

    // Reference model: a job is a script of fixed commands, then a count of
    // beats still owed, then a count of flush cycles, then the idle wait.
    bit   m_active, m_done, m_wait, m_to;
    int   m_len, m_beats, m_drain, m_wn;
    cmd_t m_out;
    cmd_t m_script[$];

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_active = 0; m_done = 0; m_wait = 0; m_to = 0;
            m_beats = 0; m_drain = 0; m_wn = 0; m_out = '0;
            m_script.delete();
        end else begin
            m_out = '0;
            if (!m_active) begin
                if (start_i) begin
                    m_active = 1; m_to = 0; m_done = 0; m_wait = 0; m_drain = 0;
                    m_len = int'(conv_len_i); m_beats = m_len;
                    m_script.delete();
                    m_script.push_back(mk(C_RESET, 0, 0, 0, 0));
                    m_script.push_back(mk(C_CONV, {16'd0, conv_len_i}, 0, 0, 0));
                    if (preload_en_i && m_len != 0) m_script.push_back(mk(C_LOAD, 0, preload_data_i, 0, 0));
                end
            end else if (abort_i) begin
                m_out = mk(C_RESET, 0, 0, 0, 0);
                m_active = 0; m_done = 0; m_wait = 0; m_beats = 0; m_drain = 0;
                m_script.delete();
            end else if (m_done) begin
                m_active = 0; m_done = 0;
            end else if (m_script.size() != 0) begin
                m_out = m_script.pop_front();
                if (m_script.size() == 0 && m_len == 0) m_done = 1;
            end else if (m_beats > 0) begin
                if (bus.s_valid) begin
                    m_out = mk((m_beats == 1) ? C_TLAST : C_TRIG, 0, 0, bus.s_data, bus.s_weight);
                    m_beats--;
                    if (m_beats == 0) begin
                        m_drain = NPE - 1; m_wn = 0; m_wait = (m_drain == 0);
                    end
                end
            end else if (m_drain > 0) begin
                m_out = mk(C_FWD, 0, 0, 0, 0);
                m_drain--;
                if (m_drain == 0) begin m_wait = 1; m_wn = 0; end
            end else if (m_wait) begin
                if (m_wn >= MINW && busy_i == '0) begin
                    m_wait = 0; m_done = 1;
                end else if (m_wn == TMO - 1) begin
                    m_to = 1; m_wait = 0; m_done = 1;
                end else begin
                    m_wn++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_i);
        cyc_n++;
    end

    // Monitor and per-cycle comparison against the model.
    initial forever begin
        cmd_t act;
        logic exp_rdy;
        @(negedge clk_i);
        act = {bus.pe_cmd_valid, bus.pe_cmd, bus.pe_param_1, bus.pe_param_2,
               bus.pe_preload, bus.pe_data, bus.pe_weight};
        if (bus.pe_cmd_valid) begin
            log_q.push_back(act);
            if (bus.pe_cmd == 9'(C_FWD)) fwd_cyc = cyc_n;
        end
        if (done_o) begin n_done++; done_cyc = cyc_n; end
        exp_rdy = m_active && !m_done && m_script.size() == 0 && m_beats > 0 && !abort_i;
        chk("pe_out", 256'(act), 256'(m_out));
        chk("ctl{rdy,busy,done,to}", 256'({bus.s_ready, ctrl_busy_o, done_o, timeout_o}),
            256'({exp_rdy, m_active, m_active && m_done && !abort_i, m_to}));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input int len, input bit pe, input logic [31:0] pd);
        start_i = 1'b1; conv_len_i = 16'(len); preload_en_i = pe; preload_data_i = pd;
        log_q.delete(); n_done = 0; st_cyc = cyc_n;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && n_done == 0; i++) tick();
        tick();
    endtask

    // Compare the logged command codes with a nibble-packed list, entry 0 in the low nibble.
    task automatic chk_seq(input string nm, input int n, input logic [63:0] codes);
        chk({nm, "_count"}, 256'(log_q.size()), 256'(n));
        for (int i = 0; i < n; i++)
            chk(nm, (i < log_q.size()) ? 256'(log_q[i].cmd) : {256{1'b1}}, 256'(codes[4*i +: 4]));
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_weight = '0;
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outs", 256'({ctrl_busy_o, done_o, timeout_o, bus.pe_cmd_valid, bus.s_ready, bus.pe_cmd}), 256'(0));
        tick();
        rst_i = 1'b0;
        tick();

        // len=4, stream always valid, row idle
        bus.s_valid = 1'b1; bus.s_data = 32'h1111_0001; bus.s_weight = 32'h2222_0002;
        start_job(4, 0, 32'h0);
        wait_done(100);
        chk_seq("len4_seq", 13, 64'h8888888211160);
        chk("len4_p1", (log_q.size() >= 2) ? 256'(log_q[1].p1) : {256{1'b1}}, 256'(4));
        chk("len4_done_cnt", 256'(n_done), 256'(1));
        chk("len4_wait_lat", 256'(done_cyc - fwd_cyc), 256'(17));
        chk("len4_idle", 256'(ctrl_busy_o), 256'(0));

        // len=3, valid toggling 1,0,1,0,1 from the first RUN cycle
        bus.s_valid = 1'b0;
        start_job(3, 0, 32'h0);
        tick(); tick();
        bus.s_valid = 1'b1; bus.s_data = 32'hA1; bus.s_weight = 32'hB1; tick();
        bus.s_valid = 1'b0; tick();
        bus.s_valid = 1'b1; bus.s_data = 32'hA2; bus.s_weight = 32'hB2; tick();
        bus.s_valid = 1'b0; tick();
        bus.s_valid = 1'b1; bus.s_data = 32'hA3; bus.s_weight = 32'hB3; tick();
        bus.s_valid = 1'b0;
        wait_done(100);
        chk_seq("tog_seq", 12, 64'h888888821160);
        chk("tog_data", (log_q.size() >= 5) ? 256'({log_q[2].data, log_q[3].data, log_q[4].data}) : {256{1'b1}},
            256'({32'hA1, 32'hA2, 32'hA3}));
        chk("tog_wgt", (log_q.size() >= 5) ? 256'({log_q[2].wgt, log_q[3].wgt, log_q[4].wgt}) : {256{1'b1}},
            256'({32'hB1, 32'hB2, 32'hB3}));

        // preload between config and first trigger
        bus.s_valid = 1'b1;
        start_job(2, 1, 32'h3F80_0000);
        wait_done(100);
        chk_seq("pre_seq", 12, 64'h888888821560);
        chk("pre_val", (log_q.size() >= 3) ? 256'(log_q[2].pre) : {256{1'b1}}, 256'(32'h3F80_0000));

        // one PE stuck busy -> timeout after 4096 WAIT cycles
        busy_i = 8'h20;
        start_job(1, 0, 32'h0);
        wait_done(5000);
        chk("to_flag", 256'(timeout_o), 256'(1));
        chk("to_done_cnt", 256'(n_done), 256'(1));
        chk("to_lat", 256'(done_cyc - fwd_cyc), 256'(4096));
        busy_i = 8'h00;

        // len=0 job: next start clears timeout, done right after config
        start_job(0, 1, 32'h5);
        @(negedge clk_i);
        chk("to_cleared", 256'(timeout_o), 256'(0));
        wait_done(20);
        chk_seq("len0_seq", 2, 64'h60);
        chk("len0_done_lat", 256'(done_cyc - st_cyc), 256'(3));
        chk("len0_done_cnt", 256'(n_done), 256'(1));

        // abort on the second RUN beat
        bus.s_valid = 1'b1;
        start_job(5, 0, 32'h0);
        tick(); tick(); tick();
        abort_i = 1'b1;
        @(negedge clk_i);
        chk("abt_rdy", 256'(bus.s_ready), 256'(0));
        tick();
        abort_i = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk_seq("abt_seq", 4, 64'h0160);
        chk("abt_no_done", 256'(n_done), 256'(0));
        chk("abt_idle", 256'(ctrl_busy_o), 256'(0));

        // reset in the middle of DRAIN
        start_job(2, 0, 32'h0);
        repeat (5) tick();
        @(negedge clk_i);
        chk("drain_fwd", 256'({bus.pe_cmd_valid, bus.pe_cmd}), 256'({1'b1, 9'd8}));
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_outs", 256'({ctrl_busy_o, done_o, bus.s_ready, bus.pe_cmd_valid, bus.pe_cmd,
                                  bus.pe_param_1, bus.pe_data, bus.pe_weight}), 256'(0));
        tick();
        rst_i = 1'b0;
        bus.s_valid = 1'b0;
        tick();

        // random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            start_i        = ($urandom_range(0, 15) == 0);
            conv_len_i     = 16'($urandom_range(0, 10));
            preload_en_i   = 1'($urandom_range(0, 1));
            preload_data_i = $urandom;
            abort_i        = ($urandom_range(0, 99) == 0);
            bus.s_valid    = ($urandom_range(0, 3) != 0);
            bus.s_data     = $urandom;
            bus.s_weight   = $urandom;
            busy_i         = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rst_i          = ($urandom_range(0, 1999) == 0);
            log_q.delete();
            tick();
        end
        start_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0; bus.s_valid = 1'b0; busy_i = '0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
